accel_desc_sched: RTL and testbench
===================================

Name: accel_desc_sched

Overview:
- Descriptor scheduler that sits between the core's descriptor source and the accelerator read DMA.
- Holds one pending descriptor per accelerator and issues at most one descriptor per cycle to the DMA, round-robin among accelerators.
- Issues only to idle accelerators, so the DMA never receives a descriptor for a busy accelerator and never raises desc_error in normal operation.
- Generates per-accelerator stop pulses, completion pulses and sticky error status.

Parameters:
ACCEL_COUNT, 16, number of accelerators / DMA destinations
DEST_WIDTH, $clog2(ACCEL_COUNT), accelerator id width
ADDR_WIDTH, 18, descriptor byte address width
LEN_WIDTH, 14, descriptor byte length width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_desc_accel_id  in  DEST_WIDTH  incoming descriptor target accelerator
s_desc_addr  in  ADDR_WIDTH  incoming descriptor byte address
s_desc_len  in  LEN_WIDTH  incoming descriptor byte length
s_desc_valid  in  1  incoming descriptor valid
s_desc_ready  out  1  incoming descriptor accepted when high with valid
stop_req  in  ACCEL_COUNT  per-accelerator stop request pulse
desc_accel_id  out  DEST_WIDTH  DMA descriptor id
desc_addr  out  ADDR_WIDTH  DMA descriptor address
desc_len  out  LEN_WIDTH  DMA descriptor length
desc_valid  out  1  DMA descriptor strobe, single cycle, no backpressure
accel_stop  out  ACCEL_COUNT  DMA stop pulse
accel_busy  in  ACCEL_COUNT  DMA busy per accelerator
desc_error  in  ACCEL_COUNT  DMA descriptor error flags
pending  out  ACCEL_COUNT  slot occupied (queued or launched, not yet seen busy)
done_pulse  out  ACCEL_COUNT  one-cycle completion pulse
err_sticky  out  ACCEL_COUNT  sticky error status

Behaviour:
- Reset (rst_n=0 at posedge): clear all pending/launched state, busy history, and the RR pointer (pointer=0). All outputs read 0, except s_desc_ready, which is combinational.
- Accept:
  - s_desc_ready = !slot_full[s_desc_accel_id]; combinational on the id only, never on s_desc_valid.
  - slot_full[i] = queued[i] | launched[i].
  - On valid & ready: store addr and len, and set queued[id] next cycle.
  - s_desc_len==0: accept, store nothing, and pulse done_pulse[id] one cycle after acceptance.
- Eligibility: elig[i] = queued[i] & ~accel_busy[i] & ~launched[i] & ~stop_req[i].
- Arbitration and issue:
  - Round-robin grant over elig, searching upward from the RR pointer with wrap-around; RR pointer = granted index + 1 (mod ACCEL_COUNT).
  - desc_* and desc_valid are registered. Accept at cycle T gives queued at T+1 and earliest desc_valid at T+2.
  - On grant g: queued[g] clears, launched[g] sets.
  - desc_valid drops the next cycle unless another grant occurs (back-to-back grants to different ids are allowed).
- Launched clear:
  - launched[i] clears on the first cycle accel_busy[i]=1; the DMA raises busy 2 cycles after desc_valid.
  - launched[i] also clears on stop_req[i].
  - The slot is reusable once both queued and launched are clear, so a new descriptor may queue while the accelerator is busy.
- Completion: done_pulse[i] = busy_q[i] & ~accel_busy[i] & ~stop_seen[i], where busy_q is accel_busy registered one cycle. Output is registered: one pulse per falling edge.
- Stop:
  - stop_req[i] clears queued[i] and launched[i] and registers accel_stop[i]=1 for exactly one cycle.
  - It sets stop_seen[i], which suppresses done_pulse[i] for the busy fall caused by the stop. stop_seen[i] clears on the next grant to i.
  - stop_req[i] with an accept for i in the same cycle: the descriptor is accepted and discarded (stop wins).
  - stop_req[i] with elig[i] in the same cycle: i is masked and another id may be granted.
- Errors: err_sticky[i] |= desc_error[i] each cycle. Cleared by reset or stop_req[i]; if both are set in the same cycle, set wins.
- Simultaneous grant of i and accept for i: impossible, because ready is low while queued[i].
- Widths: addr and len pass through unmodified. The RR pointer is DEST_WIDTH bits; for a non-power-of-2 ACCEL_COUNT the wrap to 0 is explicit.

Test Plan:
- Basic issue: accept id=3, addr=0x100, len=64 at T -> desc_valid at T+2 with id 3, addr 0x100, len 64. pending[3]=1 until accel_busy[3] rises at T+4. When busy falls, done_pulse[3]=1 for 1 cycle.
- Busy hold-off and RR fairness: queue ids 1, 2, 5 with accel_busy[2]=1 -> grants in order 1, 5. Release busy[2] -> then 2. Repeat with the pointer at 6 -> wrap-around grants 1 before 5.
- Slot full: second descriptor to id 4 while queued[4]=1 -> s_desc_ready=0. After launched[4] clears (busy seen), ready=1 even while busy[4]=1. The new descriptor issues only after busy[4] falls.
- Stop mid-operation: id 7 launched and busy; pulse stop_req[7] -> accel_stop[7]=1 for one cycle and pending[7]=0. No done_pulse when busy drops; err_sticky[7] is cleared.
- Zero length and collisions: len=0 to id 0 -> no desc_valid, done_pulse[0] one cycle later. stop_req[9] in the same cycle as accept id 9 -> nothing issued.
- Reset mid-operation: rst_n=0 while 3 descriptors are queued -> next cycle pending=0, desc_valid=0, accel_stop=0, and the RR pointer restarts at 0.

Source files
------------

// File: rtl/accel_desc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : accel_desc_sched
//  Description : Descriptor scheduler between the core descriptor source and
//                the accelerator read DMA. Holds one pending descriptor per
//                accelerator, issues at most one descriptor per cycle
//                round-robin to idle accelerators, and produces stop pulses,
//                completion pulses and sticky error status.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_desc_sched #(
    parameter int ACCEL_COUNT = 16,
    parameter int DEST_WIDTH  = $clog2(ACCEL_COUNT),
    parameter int ADDR_WIDTH  = 18,
    parameter int LEN_WIDTH   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DEST_WIDTH-1:0]  s_desc_accel_id,
    input  logic [ADDR_WIDTH-1:0]  s_desc_addr,
    input  logic [LEN_WIDTH-1:0]   s_desc_len,
    input  logic                   s_desc_valid,
    output logic                   s_desc_ready,
    input  logic [ACCEL_COUNT-1:0] stop_req,
    output logic [DEST_WIDTH-1:0]  desc_accel_id,
    output logic [ADDR_WIDTH-1:0]  desc_addr,
    output logic [LEN_WIDTH-1:0]   desc_len,
    output logic                   desc_valid,
    output logic [ACCEL_COUNT-1:0] accel_stop,
    input  logic [ACCEL_COUNT-1:0] accel_busy,
    input  logic [ACCEL_COUNT-1:0] desc_error,
    output logic [ACCEL_COUNT-1:0] pending,
    output logic [ACCEL_COUNT-1:0] done_pulse,
    output logic [ACCEL_COUNT-1:0] err_sticky
);

    localparam logic [DEST_WIDTH:0]   c_count = (DEST_WIDTH+1)'(ACCEL_COUNT);
    localparam logic [DEST_WIDTH-1:0] c_last  = DEST_WIDTH'(ACCEL_COUNT - 1);

    // Per-accelerator slot state
    logic [ACCEL_COUNT-1:0] r_queued;
    logic [ACCEL_COUNT-1:0] r_launched;
    logic [ACCEL_COUNT-1:0] r_busy_q;
    logic [ACCEL_COUNT-1:0] r_stop_seen;
    logic [ACCEL_COUNT-1:0] r_err_sticky;
    logic [ACCEL_COUNT-1:0] r_accel_stop;
    logic [ACCEL_COUNT-1:0] r_done_pulse;
    logic [DEST_WIDTH-1:0]  r_ptr;

    // Descriptor storage (no reset needed: only read after being written)
    logic [ADDR_WIDTH-1:0]  r_addr [ACCEL_COUNT];
    logic [LEN_WIDTH-1:0]   r_len  [ACCEL_COUNT];

    // Registered DMA descriptor port
    logic [DEST_WIDTH-1:0]  r_desc_id;
    logic [ADDR_WIDTH-1:0]  r_desc_addr;
    logic [LEN_WIDTH-1:0]   r_desc_len;
    logic                   r_desc_valid;

    logic [ACCEL_COUNT-1:0] w_full;
    logic [ACCEL_COUNT-1:0] w_elig;
    logic                   w_accept;
    logic [ACCEL_COUNT-1:0] w_acc_set;
    logic [ACCEL_COUNT-1:0] w_zero_done;
    logic                   w_grant_vld;
    logic [DEST_WIDTH-1:0]  w_grant_idx;
    logic [ACCEL_COUNT-1:0] w_grant_vec;
    logic [DEST_WIDTH:0]    w_scan;

    assign w_full       = r_queued | r_launched;
    assign s_desc_ready = ~w_full[s_desc_accel_id];
    assign w_accept     = s_desc_valid & s_desc_ready;
    assign w_elig       = r_queued & ~accel_busy & ~r_launched & ~stop_req;

    // Decode an accepted descriptor into a queue set or an immediate completion;
    // a stop for the same id in the same cycle discards it entirely
    always_comb begin
        w_acc_set   = '0;
        w_zero_done = '0;
        if (w_accept && !stop_req[s_desc_accel_id]) begin
            if (s_desc_len == '0) begin
                w_zero_done[s_desc_accel_id] = 1'b1;
            end else begin
                w_acc_set[s_desc_accel_id] = 1'b1;
            end
        end
    end

    // Round-robin search upward from the pointer with explicit wrap to 0
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        w_scan      = '0;
        for (int k = 0; k < ACCEL_COUNT; k++) begin
            w_scan = {1'b0, r_ptr} + (DEST_WIDTH+1)'(k);
            if (w_scan >= c_count) begin
                w_scan = w_scan - c_count;
            end
            if (!w_grant_vld && w_elig[w_scan[DEST_WIDTH-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan[DEST_WIDTH-1:0];
            end
        end
        if (w_grant_vld) begin
            w_grant_vec[w_grant_idx] = 1'b1;
        end
    end

    // Capture descriptor payload into the target slot on a non-empty accept
    always_ff @(posedge clk) begin
        if (|w_acc_set) begin
            r_addr[s_desc_accel_id] <= s_desc_addr;
            r_len[s_desc_accel_id]  <= s_desc_len;
        end
    end

    // Slot state, status flags, RR pointer and registered DMA descriptor port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_queued     <= '0;
            r_launched   <= '0;
            r_busy_q     <= '0;
            r_stop_seen  <= '0;
            r_err_sticky <= '0;
            r_accel_stop <= '0;
            r_done_pulse <= '0;
            r_ptr        <= '0;
            r_desc_id    <= '0;
            r_desc_addr  <= '0;
            r_desc_len   <= '0;
            r_desc_valid <= 1'b0;
        end else begin
            r_queued     <= (r_queued & ~w_grant_vec & ~stop_req) | w_acc_set;
            // Busy seen means the DMA owns the descriptor; the slot frees up
            r_launched   <= (r_launched & ~accel_busy & ~stop_req) | w_grant_vec;
            r_busy_q     <= accel_busy;
            r_stop_seen  <= (r_stop_seen & ~w_grant_vec) | stop_req;
            // Error set has priority over the stop clear
            r_err_sticky <= (r_err_sticky & ~stop_req) | desc_error;
            r_accel_stop <= stop_req;
            r_done_pulse <= (r_busy_q & ~accel_busy & ~r_stop_seen) | w_zero_done;
            r_desc_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_desc_id   <= w_grant_idx;
                r_desc_addr <= r_addr[w_grant_idx];
                r_desc_len  <= r_len[w_grant_idx];
                r_ptr       <= (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign desc_accel_id = r_desc_id;
    assign desc_addr     = r_desc_addr;
    assign desc_len      = r_desc_len;
    assign desc_valid    = r_desc_valid;
    assign accel_stop    = r_accel_stop;
    assign pending       = w_full;
    assign done_pulse    = r_done_pulse;
    assign err_sticky    = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_accel_desc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accel_desc_sched
//  Description : Directed self-checking bench for accel_desc_sched. The bench
//                plays the DMA by driving accel_busy/desc_error by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_desc_sched;

    localparam int c_n  = 16;
    localparam int c_dw = 4;
    localparam int c_aw = 18;
    localparam int c_lw = 14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [c_dw-1:0] s_desc_accel_id;
    logic [c_aw-1:0] s_desc_addr;
    logic [c_lw-1:0] s_desc_len;
    logic            s_desc_valid;
    logic            s_desc_ready;
    logic [c_n-1:0]  stop_req;
    logic [c_dw-1:0] desc_accel_id;
    logic [c_aw-1:0] desc_addr;
    logic [c_lw-1:0] desc_len;
    logic            desc_valid;
    logic [c_n-1:0]  accel_stop;
    logic [c_n-1:0]  accel_busy;
    logic [c_n-1:0]  desc_error;
    logic [c_n-1:0]  pending;
    logic [c_n-1:0]  done_pulse;
    logic [c_n-1:0]  err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    accel_desc_sched #(
        .ACCEL_COUNT (c_n),
        .DEST_WIDTH  (c_dw),
        .ADDR_WIDTH  (c_aw),
        .LEN_WIDTH   (c_lw)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_desc_accel_id (s_desc_accel_id),
        .s_desc_addr     (s_desc_addr),
        .s_desc_len      (s_desc_len),
        .s_desc_valid    (s_desc_valid),
        .s_desc_ready    (s_desc_ready),
        .stop_req        (stop_req),
        .desc_accel_id   (desc_accel_id),
        .desc_addr       (desc_addr),
        .desc_len        (desc_len),
        .desc_valid      (desc_valid),
        .accel_stop      (accel_stop),
        .accel_busy      (accel_busy),
        .desc_error      (desc_error),
        .pending         (pending),
        .done_pulse      (done_pulse),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input int addr, input int len);
        s_desc_accel_id = c_dw'(id);
        s_desc_addr     = c_aw'(addr);
        s_desc_len      = c_lw'(len);
        s_desc_valid    = 1'b1;
        tick();
        s_desc_valid    = 1'b0;
    endtask

    task automatic check_desc(input string tag, input int id, input int addr, input int len);
        check({tag, "_valid"}, 32'(desc_valid), 32'd1);
        check({tag, "_id"},    32'(desc_accel_id), 32'(id));
        check({tag, "_addr"},  32'(desc_addr), 32'(addr));
        check({tag, "_len"},   32'(desc_len), 32'(len));
    endtask

    initial begin
        rst_n = 1'b0; s_desc_accel_id = '0; s_desc_addr = '0; s_desc_len = '0;
        s_desc_valid = 1'b0; stop_req = '0; accel_busy = '0; desc_error = '0;
        tick(); tick();
        // Reset state
        check("rst_desc_valid", 32'(desc_valid), 32'd0);
        check("rst_pending",    32'(pending), 32'd0);
        check("rst_accel_stop", 32'(accel_stop), 32'd0);
        check("rst_done",       32'(done_pulse), 32'd0);
        check("rst_err",        32'(err_sticky), 32'd0);
        check("rst_desc_id",    32'(desc_accel_id), 32'd0);
        check("rst_ready",      32'(s_desc_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Round robin with busy hold-off, pointer starts at 0
        accel_busy = 16'h0026;
        send(1, 'h1000, 16); send(2, 'h2000, 32); send(5, 'h5000, 48);
        check("rr_pending", 32'(pending), 32'h0026);
        check("rr_no_issue", 32'(desc_valid), 32'd0);
        accel_busy = 16'h0004;
        tick();
        check_desc("rr_g1", 1, 'h1000, 16);
        check("rr_done_15", 32'(done_pulse), 32'h0022);
        tick();
        check_desc("rr_g5", 5, 'h5000, 48);
        tick();
        check("rr_hold2", 32'(desc_valid), 32'd0);
        accel_busy = '0;
        tick();
        check_desc("rr_g2", 2, 'h2000, 32);
        accel_busy = 16'h0026; tick(); accel_busy = '0; tick(); tick();
        check("rr_drained", 32'(pending), 32'd0);
        // Move pointer to 6, then 1 and 5 eligible together: wrap gives 1 first
        send(5, 'h5500, 8);
        tick();
        check_desc("wrap_pre5", 5, 'h5500, 8);
        accel_busy = 16'h0020; tick(); accel_busy = '0; tick();
        accel_busy = 16'h0022;
        send(1, 'h1100, 4); send(5, 'h5100, 12);
        accel_busy = '0;
        tick();
        check_desc("wrap_g1", 1, 'h1100, 4);
        tick();
        check_desc("wrap_g5", 5, 'h5100, 12);
        accel_busy = 16'h0022; tick(); accel_busy = '0; tick(); tick();

        // Basic issue, launch, busy and completion
        send(3, 'h100, 64);
        check("basic_pend_q", 32'(pending), 32'h0008);
        check("basic_t1_valid", 32'(desc_valid), 32'd0);
        tick();
        check_desc("basic", 3, 'h100, 64);
        tick();
        check("basic_t3_valid", 32'(desc_valid), 32'd0);
        check("basic_t3_pend", 32'(pending), 32'h0008);
        tick();
        accel_busy = 16'h0008;
        check("basic_t4_pend", 32'(pending), 32'h0008);
        tick();
        check("basic_t5_pend", 32'(pending), 32'h0000);
        tick();
        accel_busy = '0;
        tick();
        check("basic_done", 32'(done_pulse), 32'h0008);
        tick();
        check("basic_done_end", 32'(done_pulse), 32'h0000);

        // Slot full and reuse while busy
        accel_busy = 16'h0010;
        send(4, 'h400, 8);
        check("full_ready_q", 32'(s_desc_ready), 32'd0);
        accel_busy = '0;
        tick();
        check_desc("full_g4", 4, 'h400, 8);
        check("full_ready_l", 32'(s_desc_ready), 32'd0);
        accel_busy = 16'h0010;
        tick();
        check("full_ready_busy", 32'(s_desc_ready), 32'd1);
        send(4, 'h480, 24);
        check("full_pend2", 32'(pending), 32'h0010);
        tick();
        check("full_wait", 32'(desc_valid), 32'd0);
        accel_busy = '0;
        tick();
        check_desc("full_g4b", 4, 'h480, 24);
        check("full_done", 32'(done_pulse), 32'h0010);
        accel_busy = 16'h0010; tick(); accel_busy = '0; tick(); tick();

        // Stop mid-operation
        send(7, 'h700, 128);
        tick();
        check_desc("stop_g7", 7, 'h700, 128);
        accel_busy = 16'h0080; desc_error = 16'h0080;
        tick();
        desc_error = '0;
        check("stop_err_set", 32'(err_sticky), 32'h0080);
        send(7, 'h780, 16);
        check("stop_pend", 32'(pending), 32'h0080);
        stop_req = 16'h0080;
        tick();
        stop_req = '0;
        check("stop_pulse", 32'(accel_stop), 32'h0080);
        check("stop_pend_clr", 32'(pending), 32'h0000);
        check("stop_err_clr", 32'(err_sticky), 32'h0000);
        tick();
        check("stop_pulse_end", 32'(accel_stop), 32'h0000);
        accel_busy = '0;
        tick();
        check("stop_no_done", 32'(done_pulse), 32'h0000);
        tick();
        check("stop_no_done2", 32'(done_pulse), 32'h0000);
        check("stop_no_issue", 32'(desc_valid), 32'd0);

        // Zero length
        send(0, 'h40, 0);
        check("zero_done", 32'(done_pulse), 32'h0001);
        check("zero_pend", 32'(pending), 32'h0000);
        tick();
        check("zero_done_end", 32'(done_pulse), 32'h0000);
        check("zero_no_issue", 32'(desc_valid), 32'd0);

        // Stop collides with accept
        stop_req = 16'h0200;
        send(9, 'h900, 32);
        stop_req = '0;
        check("coll_pend", 32'(pending), 32'h0000);
        check("coll_stop", 32'(accel_stop), 32'h0200);
        tick();
        check("coll_no_issue", 32'(desc_valid), 32'd0);

        // Stop masks an eligible id; another id is granted
        accel_busy = 16'h0C00;
        send(10, 'hA00, 20); send(11, 'hB00, 28);
        accel_busy = '0; stop_req = 16'h0400;
        tick();
        stop_req = '0;
        check_desc("mask_g11", 11, 'hB00, 28);
        check("mask_pend", 32'(pending), 32'h0800);
        accel_busy = 16'h0800; tick(); accel_busy = '0; tick();

        // Reset mid-operation, pointer returns to 0
        accel_busy = 16'h7000;
        send(12, 'hC00, 4); send(13, 'hD00, 4); send(14, 'hE00, 4);
        check("mrst_pend_pre", 32'(pending), 32'h7000);
        rst_n = 1'b0;
        tick();
        check("mrst_pend", 32'(pending), 32'h0000);
        check("mrst_valid", 32'(desc_valid), 32'd0);
        check("mrst_stop", 32'(accel_stop), 32'h0000);
        rst_n = 1'b1;
        accel_busy = 16'h8008;
        tick();
        send(3, 'h300, 4); send(15, 'hF00, 4);
        accel_busy = '0;
        tick();
        check_desc("mrst_g3", 3, 'h300, 4);
        tick();
        check_desc("mrst_g15", 15, 'hF00, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
